// File: rtl/reg_encode.sv
// +----------------------------------------------------------------------------+
// | reg_encode: turns a 4-bit register address into a play-area set plus a     |
// | 2-bit lower access, skipping the play-area set when the shadow matches.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module reg_encode (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [3:0] req_addr,
  input  logic       pa_flush,
  output logic       req_ready,
  output logic [2:0] set_pa,
  output logic [1:0] lower_reg_addr,
  output logic       addr_valid,
  output logic [1:0] pa_shadow,
  output logic       pa_shadow_valid,
  output logic [7:0] switch_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SET_PA = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t     state_q;
  logic [3:0] addr_q;
  logic       req_ready_q;
  logic [2:0] set_pa_q;
  logic [1:0] lower_q;
  logic       addr_valid_q;
  logic [1:0] shadow_q;
  logic       shadow_valid_q;
  logic [7:0] count_q;
  logic [7:0] count_d;
  logic       hit;

  // A flush in the accept cycle wins over a shadow match.
  assign hit     = shadow_valid_q && (shadow_q == req_addr[3:2]) && !pa_flush;
  assign count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      addr_q         <= 4'b0000;
      req_ready_q    <= 1'b1;
      set_pa_q       <= 3'b000;
      lower_q        <= 2'b00;
      addr_valid_q   <= 1'b0;
      shadow_q       <= 2'b00;
      shadow_valid_q <= 1'b0;
      count_q        <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (pa_flush) begin
            shadow_valid_q <= 1'b0;
          end
          if (req_valid) begin
            addr_q      <= req_addr;
            req_ready_q <= 1'b0;
            if (hit) begin
              state_q      <= ACCESS;
              lower_q      <= req_addr[1:0];
              addr_valid_q <= 1'b1;
            end else begin
              state_q  <= SET_PA;
              set_pa_q <= {1'b1, req_addr[3:2]};
            end
          end
        end
        SET_PA: begin
          state_q        <= ACCESS;
          set_pa_q       <= 3'b000;
          lower_q        <= addr_q[1:0];
          addr_valid_q   <= 1'b1;
          shadow_q       <= addr_q[3:2];
          shadow_valid_q <= !pa_flush;
          count_q        <= count_d;
        end
        ACCESS: begin
          state_q      <= IDLE;
          lower_q      <= 2'b00;
          addr_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          if (pa_flush) begin
            shadow_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          set_pa_q     <= 3'b000;
          lower_q      <= 2'b00;
          addr_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready       = req_ready_q;
  assign set_pa          = set_pa_q;
  assign lower_reg_addr  = lower_q;
  assign addr_valid      = addr_valid_q;
  assign pa_shadow       = shadow_q;
  assign pa_shadow_valid = shadow_valid_q;
  assign switch_count    = count_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_encode.sv
// +----------------------------------------------------------------------------+
// | tb_reg_encode: directed and random requests against reg_encode, checked    |
// | by a scoreboard and a decoder model. Revision: 1.0                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_reg_encode;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic [3:0] req_addr;
  logic       pa_flush;
  logic       req_ready;
  logic [2:0] set_pa;
  logic [1:0] lower_reg_addr;
  logic       addr_valid;
  logic [1:0] pa_shadow;
  logic       pa_shadow_valid;
  logic [7:0] switch_count;

  reg_encode dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .pa_flush       (pa_flush),
    .req_ready      (req_ready),
    .set_pa         (set_pa),
    .lower_reg_addr (lower_reg_addr),
    .addr_valid     (addr_valid),
    .pa_shadow      (pa_shadow),
    .pa_shadow_valid(pa_shadow_valid),
    .switch_count   (switch_count)
  );

  typedef struct packed {
    logic [3:0] addr;
    logic       miss;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  logic [1:0] dec_pa = 2'b00;
  logic       saw_set = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decoder model plus scoreboard: set_pa writes the area, the access pairs it
  // with lower_reg_addr and must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      saw_set = 1'b0;
    end else begin
      if (set_pa[2]) begin
        dec_pa  = set_pa[1:0];
        saw_set = 1'b1;
      end
      if (addr_valid) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL spurious_access: addr_valid=1 addr=%b, expected no access", {dec_pa, lower_reg_addr});
        end else begin
          e = sbq.pop_front();
          if ({dec_pa, lower_reg_addr} !== e.addr) begin
            errors++;
            $display("FAIL decoder_addr: got %b expected %b", {dec_pa, lower_reg_addr}, e.addr);
          end
          checks++;
          if (saw_set !== e.miss) begin
            errors++;
            $display("FAIL set_pa_issued: got %b expected %b (addr %b)", saw_set, e.miss, e.addr);
          end
          checks++;
          if (set_pa !== 3'b000) begin
            errors++;
            $display("FAIL set_pa_in_access: got %b expected 000", set_pa);
          end
        end
        saw_set = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},  {7'd0, req_ready}, 8'd1);
    chk({tag, "_set_pa"}, {5'd0, set_pa}, 8'd0);
    chk({tag, "_lower"},  {6'd0, lower_reg_addr}, 8'd0);
    chk({tag, "_av"},     {7'd0, addr_valid}, 8'd0);
    chk({tag, "_shadow"}, {6'd0, pa_shadow}, 8'd0);
    chk({tag, "_shv"},    {7'd0, pa_shadow_valid}, 8'd0);
    chk({tag, "_count"},  switch_count, 8'd0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: req_ready=%b expected 1", req_ready);
    end
  endtask

  // Returns #1 after the accepting edge.
  task automatic issue(input logic [3:0] a, input logic fl, input logic miss);
    exp_t e;
    wait_ready();
    e.addr = a;
    e.miss = miss;
    sbq.push_back(e);
    req_valid = 1'b1;
    req_addr  = a;
    pa_flush  = fl;
    @(posedge clk); #1;
    req_valid = 1'b0;
    pa_flush  = 1'b0;
    req_addr  = 4'($urandom_range(0, 15));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    sbq.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] a;
    logic       fl;
    logic       miss;
    logic [1:0] sh;
    logic       shv;
    int         n;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = 4'b0000;
    pa_flush  = 1'b0;
    @(posedge clk); #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // First request is a miss: SET_PA then ACCESS.
    issue(4'b1001, 1'b0, 1'b1);
    chk("miss_set_pa", {5'd0, set_pa}, 8'h06);
    chk("miss_av_early", {7'd0, addr_valid}, 8'd0);
    @(posedge clk); #1;
    chk("miss_av", {7'd0, addr_valid}, 8'd1);
    chk("miss_lower", {6'd0, lower_reg_addr}, 8'h01);
    @(posedge clk); #1;
    chk("shadow_after_miss", {6'd0, pa_shadow}, 8'h02);
    chk("shv_after_miss", {7'd0, pa_shadow_valid}, 8'd1);
    chk("count_after_miss", switch_count, 8'd1);

    // Same area: hit, access on the very next cycle.
    issue(4'b1011, 1'b0, 1'b0);
    chk("hit_av", {7'd0, addr_valid}, 8'd1);
    chk("hit_lower", {6'd0, lower_reg_addr}, 8'h03);
    chk("hit_set_pa", {5'd0, set_pa}, 8'd0);
    chk("hit_count", switch_count, 8'd1);
    @(posedge clk); #1;

    // Flush coincident with an accept that would otherwise hit.
    issue(4'b1000, 1'b1, 1'b1);
    chk("flushacc_set_pa", {5'd0, set_pa}, 8'h06);
    @(posedge clk); #1;
    chk("flushacc_av", {7'd0, addr_valid}, 8'd1);
    chk("flushacc_lower", {6'd0, lower_reg_addr}, 8'h00);
    @(posedge clk); #1;

    // Flush in IDLE invalidates but keeps the shadow value.
    pa_flush = 1'b1;
    @(posedge clk); #1;
    pa_flush = 1'b0;
    chk("idle_flush_shv", {7'd0, pa_shadow_valid}, 8'd0);
    chk("idle_flush_shadow", {6'd0, pa_shadow}, 8'h02);
    issue(4'b1000, 1'b0, 1'b1);
    chk("after_flush_set_pa", {5'd0, set_pa}, 8'h06);

    // Flush during SET_PA leaves the shadow invalid.
    issue(4'b0110, 1'b0, 1'b1);
    pa_flush = 1'b1;
    @(posedge clk); #1;
    pa_flush = 1'b0;
    chk("setpa_flush_shadow", {6'd0, pa_shadow}, 8'h01);
    chk("setpa_flush_shv", {7'd0, pa_shadow_valid}, 8'd0);
    issue(4'b0100, 1'b0, 1'b1);
    wait_ready();
    chk("count_five", switch_count, 8'd5);

    // Reset asserted mid-SET_PA abandons the request.
    issue(4'b1100, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    sbq.delete();
    chk_reset_outputs("async");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    issue(4'b1100, 1'b0, 1'b1);
    chk("post_reset_set_pa", {5'd0, set_pa}, 8'h07);
    wait_ready();
    chk("post_reset_count", switch_count, 8'd1);

    // Alternating-area misses saturate the switch counter.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      a = (i % 2 == 1) ? 4'b1101 : 4'b0010;
      issue(a, 1'b0, 1'b1);
      wait_ready();
      if (i == 253) chk("count_fe", switch_count, 8'hFE);
      if (i == 254) chk("count_ff", switch_count, 8'hFF);
    end
    chk("count_hold", switch_count, 8'hFF);

    // Random traffic with occasional coincident flushes.
    do_reset();
    sh  = 2'b00;
    shv = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      a    = 4'($urandom_range(0, 15));
      fl   = ($urandom_range(0, 7) == 0);
      miss = fl || !(shv && sh == a[3:2]);
      issue(a, fl, miss);
      sh  = a[3:2];
      shv = 1'b1;
    end

    n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("scoreboard_drained", 8'(sbq.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_encode.md
REG_ENCODE -- requirements
Module: reg_encode

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state updates on posedge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port req_valid, input, 1, register-access request present.
REQ-004 SHALL have port req_addr, input, 4, full register address; [3:2] is play area, [1:0] is lower address.
REQ-005 SHALL have port pa_flush, input, 1, single-cycle pulse that invalidates the play-area shadow.
REQ-006 SHALL have port req_ready, output, 1, block can accept a request this cycle.
REQ-007 SHALL have port set_pa, output, 3, play-area command to the decoder; bit 2 is the write enable, [1:0] is the area.
REQ-008 SHALL have port lower_reg_addr, output, 2, lower register address to the decoder.
REQ-009 SHALL have port addr_valid, output, 1, the decoder's 4-bit address equals the accepted req_addr this cycle.
REQ-010 SHALL have port pa_shadow, output, 2, current shadow of the decoder play area.
REQ-011 SHALL have port pa_shadow_valid, output, 1, pa_shadow is known to match the decoder.
REQ-012 SHALL have port switch_count, output, 8, count of SET_PA cycles issued.

Function
REQ-013 SHALL implement exactly three states: IDLE, SET_PA and ACCESS.
REQ-014 SHALL drive req_ready=1 only in IDLE; a request is accepted on a posedge with req_valid=1 and req_ready=1.
REQ-015 SHALL latch req_addr into an internal request register on accept; req_addr is don't-care after accept.
REQ-016 SHALL classify an accept as a hit when pa_shadow_valid=1, pa_shadow==req_addr[3:2] and pa_flush=0 in the accept cycle.
REQ-017 SHALL classify every other accept as a miss.
REQ-018 SHALL go IDLE->ACCESS on a hit accept.
REQ-019 SHALL go IDLE->SET_PA on a miss accept.
REQ-020 SHALL stay in IDLE with no accept.
REQ-021 SHALL in SET_PA drive set_pa={1,latched[3:2]}, lower_reg_addr=2'b00 and addr_valid=0, for exactly one cycle, then go to ACCESS.
REQ-022 SHALL at the end of a SET_PA cycle load pa_shadow<=latched[3:2] and set pa_shadow_valid<=1, unless pa_flush=1 in that cycle, in which case pa_shadow_valid<=0.
REQ-023 SHALL in ACCESS drive set_pa=3'b000, lower_reg_addr=latched[1:0] and addr_valid=1, for exactly one cycle, then go to IDLE.
REQ-024 SHALL in IDLE drive set_pa=3'b000, lower_reg_addr=2'b00 and addr_valid=0.
REQ-025 SHALL give a latency from accept edge to addr_valid high of 1 cycle on a hit and 2 cycles on a miss.
REQ-026 SHALL sustain a throughput of one request per 2 cycles on hits and per 3 cycles on misses.
REQ-027 SHALL on pa_flush=1 in IDLE or ACCESS clear pa_shadow_valid at that edge; pa_shadow keeps its value.
REQ-028 SHALL treat pa_flush coincident with an accept as flush-first, so the request is a miss.
REQ-029 SHALL increment switch_count by 1 at the end of each SET_PA cycle, saturating at 8'hFF with no wrap.
REQ-030 SHALL derive all outputs from registered state only, with no combinational path from req_valid, req_addr or pa_flush to any output.

Reset
REQ-031 SHALL on rst_n=0 immediately, asynchronously, force state=IDLE, pa_shadow=2'b00, pa_shadow_valid=0, switch_count=0, set_pa=0, lower_reg_addr=0, addr_valid=0 and req_ready=1.
REQ-032 SHALL on reset asserted mid-SET_PA or mid-ACCESS abandon the in-flight request with no later access issued, so the next request is always a miss.
REQ-033 SHALL resume normal operation on the first posedge after rst_n deasserts.

Verification
REQ-034 SHALL cover: after reset, accept req_addr=4'b1001 -> next cycle set_pa=3'b110; the cycle after, addr_valid=1 and lower_reg_addr=2'b01; then pa_shadow=2'b10, pa_shadow_valid=1, switch_count=1.
REQ-035 SHALL cover: following the REQ-034 scenario, accept 4'b1011 -> the next cycle gives addr_valid=1, lower_reg_addr=2'b11, set_pa=0 throughout, and switch_count stays 1.
REQ-036 SHALL cover: pa_flush=1 in the same cycle as accepting 4'b1000 while pa_shadow=2'b10 and valid -> SET_PA is issued with set_pa=3'b110, then ACCESS with lower_reg_addr=2'b00.
REQ-037 SHALL cover: 300 back-to-back misses alternating areas 2'b00 and 2'b11 -> switch_count reaches 8'hFF and holds at 8'hFF.
REQ-038 SHALL cover: rst_n low during SET_PA -> all outputs reset within the same cycle, no addr_valid pulse follows, and the next request goes through SET_PA.
REQ-039 SHALL cover: a decoder model driven by set_pa and lower_reg_addr -> its 4-bit address equals the latched req_addr on every addr_valid=1 cycle over 1000 random requests.
